// File: rtl/fp_norm_round_if.sv
// Operand/result handshake bundle for the FP multiplier normalize-and-round stage.
// The master drives operands and out_ready; the slave (the stage) returns results.
interface fp_norm_round_if #(
  parameter int PW = 48,
  parameter int EW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [PW-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [2:0]    out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_prod, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_prod, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fp_norm_round.sv
// Two-stage normalize / round-to-nearest-even / pack stage of the FP32 multiplier.
// Optional accumulated flags are built when FP_NORM_STICKY_FLAGS_EN is defined.
module fp_norm_round #(
  parameter int PW = 48,
  parameter int EW = 10
) (
  input  logic               clk,
  input  logic               rst,
  fp_norm_round_if.slave     bus,
  input  logic               flag_clr,
  output logic [2:0]         flags_sticky
);

  logic              s1Valid_q;
  logic              s1Zero_q;
  logic              s1Sign_q;
  logic signed [EW:0] s1Exp_q;
  logic [22:0]       s1Mant_q;
  logic              s1Guard_q;
  logic              s1Sticky_q;

  logic              normZero_d;
  logic signed [EW:0] normExp_d;
  logic [22:0]       normMant_d;
  logic              normGuard_d;
  logic              normSticky_d;

  logic              outValid_q;
  logic [31:0]       result_q;
  logic [2:0]        flags_q;
  logic [31:0]       result_d;
  logic [2:0]        flags_d;

  logic              adv1;
  logic              adv2;
  logic              roundUp;
  logic [23:0]       mantSum;
  logic signed [EW:0] expRound;
  logic              inexact;

  assign adv2         = !outValid_q || bus.out_ready;
  assign adv1         = !s1Valid_q || adv2;
  assign bus.in_ready = adv1;

  always_comb begin
    normZero_d   = (bus.in_prod[PW-1 -: 2] == 2'b00);
    normExp_d    = {bus.in_exp[EW-1], bus.in_exp};
    normMant_d   = bus.in_prod[PW-3 -: 23];
    normGuard_d  = bus.in_prod[PW-26];
    normSticky_d = |bus.in_prod[PW-27:0];
    if (bus.in_prod[PW-1]) begin
      normExp_d    = {bus.in_exp[EW-1], bus.in_exp} + (EW+1)'(1);
      normMant_d   = bus.in_prod[PW-2 -: 23];
      normGuard_d  = bus.in_prod[PW-25];
      normSticky_d = |bus.in_prod[PW-26:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Zero_q   <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Exp_q    <= '0;
      s1Mant_q   <= '0;
      s1Guard_q  <= 1'b0;
      s1Sticky_q <= 1'b0;
    end else if (adv1) begin
      s1Valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1Zero_q   <= normZero_d;
        s1Sign_q   <= bus.in_sign;
        s1Exp_q    <= normExp_d;
        s1Mant_q   <= normMant_d;
        s1Guard_q  <= normGuard_d;
        s1Sticky_q <= normSticky_d;
      end
    end
  end

  // A carry out of the 23-bit fraction leaves it zero and bumps the exponent.
  always_comb begin
    roundUp  = s1Guard_q & (s1Sticky_q | s1Mant_q[0]);
    mantSum  = {1'b0, s1Mant_q} + 24'(roundUp);
    expRound = s1Exp_q + (EW+1)'(mantSum[23]);
    inexact  = s1Guard_q | s1Sticky_q;
    result_d = {s1Sign_q, expRound[7:0], mantSum[22:0]};
    flags_d  = {2'b00, inexact};
    if (s1Zero_q) begin
      result_d = {s1Sign_q, 31'h0};
      flags_d  = 3'b000;
    end else if (expRound >= (EW+1)'(255)) begin
      result_d = {s1Sign_q, 8'hFF, 23'h0};
      flags_d  = 3'b101;
    end else if (expRound <= (EW+1)'(0)) begin
      result_d = {s1Sign_q, 31'h0};
      flags_d  = 3'b011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (adv2) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign bus.out_valid  = outValid_q;
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;

`ifdef FP_NORM_STICKY_FLAGS_EN
  logic [2:0] flagsSticky_q;
  logic       outXfer;

  assign outXfer = outValid_q & bus.out_ready;

  // A clear coinciding with a transfer keeps only that transfer's flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flagsSticky_q <= '0;
    end else if (flag_clr) begin
      flagsSticky_q <= outXfer ? flags_q : 3'b000;
    end else if (outXfer) begin
      flagsSticky_q <= flagsSticky_q | flags_q;
    end
  end

  assign flags_sticky = flagsSticky_q;
`else
  logic unusedFlagClr;
  assign unusedFlagClr = flag_clr;
  assign flags_sticky  = 3'b000;
`endif

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vector table, backpressure,
// reset-in-flight, sticky flags and randomized traffic against a value-level model.
module tb_fp_norm_round;

  logic        clk;
  logic        rst;
  logic        flag_clr;
  logic [2:0]  flags_sticky;

  int checks = 0;
  int errors = 0;

  fp_norm_round_if #(.PW(48), .EW(10)) ifc ();

  fp_norm_round dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifc.slave),
    .flag_clr     (flag_clr),
    .flags_sticky (flags_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] prod;
    logic [31:0] result;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[10];
  logic [34:0] expQ[$];
  logic        holdValid = 1'b0;
  logic [34:0] held;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [9:0] e, input logic [47:0] p);
    ifc.in_valid = v;
    ifc.in_sign  = s;
    ifc.in_exp   = e;
    ifc.in_prod  = p;
  endtask

  // Value-level reference: scale the product so its leading one is bit 47,
  // then round by comparing the discarded remainder against one half.
  function automatic logic [34:0] refModel(input logic sign, input logic signed [9:0] exp, input logic [47:0] prod);
    longint e, m, rem;
    logic [47:0] p;
    logic [7:0]  eb;
    logic [22:0] mf;
    logic        inexact;
    e = longint'(exp);
    p = prod;
    if (p[47:46] == 2'b00) return {3'b000, sign, 31'h0};
    if (p[47]) e = e + 1;
    else p = p << 1;
    m   = longint'(p[47:24]);
    rem = longint'(p[23:0]);
    if (rem > 64'h800000 || (rem == 64'h800000 && m[0])) m = m + 1;
    if (m == 64'h1000000) begin
      m = m / 2;
      e = e + 1;
    end
    inexact = (rem != 0);
    if (e >= 255) return {3'b101, sign, 8'hFF, 23'h0};
    if (e <= 0) return {3'b011, sign, 31'h0};
    eb = e[7:0];
    mf = m[22:0];
    return {2'b00, inexact, sign, eb, mf};
  endfunction

  task automatic makeRandomOp(output logic s, output logic [9:0] e, output logic [47:0] p);
    int sel, ev;
    logic [23:0] ma, mb;
    s   = 1'($urandom);
    sel = int'($urandom_range(0, 9));
    if (sel == 0) ev = int'($urandom_range(0, 6)) - 3;
    else if (sel == 1) ev = int'($urandom_range(250, 258));
    else ev = int'($urandom_range(1, 253));
    e   = 10'(ev);
    sel = int'($urandom_range(0, 15));
    ma  = {1'b1, 23'($urandom)};
    mb  = {1'b1, 23'($urandom)};
    if (sel == 0) p = {2'b00, 14'($urandom), 32'($urandom)};
    else if (sel == 1) p = {2'b01, 23'($urandom), 1'b1, 22'h0};
    else p = 48'(ma) * 48'(mb);
  endtask

  // Scoreboard: acceptances enqueue the model's answer, output transfers dequeue.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checkOutput("stall_valid", 64'(ifc.out_valid), 64'd1);
        checkOutput("stall_result", 64'({ifc.out_flags, ifc.out_result}), 64'(held));
      end
      holdValid = ifc.out_valid && !ifc.out_ready;
      held      = {ifc.out_flags, ifc.out_result};
      if (ifc.in_valid && ifc.in_ready)
        expQ.push_back(refModel(ifc.in_sign, ifc.in_exp, ifc.in_prod));
      if (ifc.out_valid && ifc.out_ready) begin
        if (expQ.size() == 0) checkOutput("unexpected_output", 64'(ifc.out_valid), 64'd0);
        else checkOutput("scoreboard", 64'({ifc.out_flags, ifc.out_result}), 64'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        s;
    logic [9:0]  e;
    logic [47:0] p;
    logic        bpS[5];
    logic [9:0]  bpE[5];
    logic [47:0] bpP[5];
    logic        acc;
    int          nAcc;

    vecs[0] = '{1'b0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000};
    vecs[1] = '{1'b0, 10'd127, 48'h9000_0000_0000, 32'h4010_0000, 3'b000};
    vecs[2] = '{1'b0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 3'b001};
    vecs[3] = '{1'b0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 3'b001};
    vecs[4] = '{1'b0, 10'd254, 48'h8000_0000_0000, 32'h7F80_0000, 3'b101};
    vecs[5] = '{1'b1, 10'd0,   48'h4000_0000_0000, 32'h8000_0000, 3'b011};
    vecs[6] = '{1'b1, 10'd127, 48'h0000_1234_5678, 32'h8000_0000, 3'b000};
    vecs[7] = '{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 32'h4000_0000, 3'b001};
    vecs[8] = '{1'b0, 10'd254, 48'h7FFF_FFC0_0000, 32'h7F80_0000, 3'b101};
    vecs[9] = '{1'b0, 10'h3FF, 48'h8000_0000_0000, 32'h0000_0000, 3'b011};

    rst = 1'b1;
    flag_clr = 1'b0;
    ifc.out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 10'd0, 48'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(ifc.out_result), 64'd0);
    checkOutput("reset_out_flags", 64'(ifc.out_flags), 64'd0);
    checkOutput("reset_flags_sticky", 64'(flags_sticky), 64'd0);
    checkOutput("reset_in_ready", 64'(ifc.in_ready), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 applyStimulus(1'b1, vecs[i].sign, vecs[i].exp, vecs[i].prod);
      @(negedge clk);
      checkOutput("vec_in_ready", 64'(ifc.in_ready), 64'd1);
      @(posedge clk);
      #1 ifc.in_valid = 1'b0;
      checkOutput("vec_latency_early", 64'(ifc.out_valid), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("vec_valid", 64'(ifc.out_valid), 64'd1);
      checkOutput("vec_result", 64'(ifc.out_result), 64'(vecs[i].result));
      checkOutput("vec_flags", 64'(ifc.out_flags), 64'(vecs[i].flags));
    end

    // Backpressure: five back-to-back operands with the output stalled four cycles.
    for (int i = 0; i < 5; i++) makeRandomOp(bpS[i], bpE[i], bpP[i]);
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    applyStimulus(1'b1, bpS[0], bpE[0], bpP[0]);
    nAcc = 0;
    for (int cyc = 0; cyc < 40 && nAcc < 5; cyc++) begin
      @(negedge clk);
      acc = ifc.in_ready;
      if (!ifc.out_ready && nAcc < 2) checkOutput("bp_in_ready_open", 64'(ifc.in_ready), 64'd1);
      if (!ifc.out_ready && nAcc == 2) checkOutput("bp_in_ready_full", 64'(ifc.in_ready), 64'd0);
      @(posedge clk);
      #1;
      if (acc) begin
        nAcc++;
        if (nAcc < 5) applyStimulus(1'b1, bpS[nAcc], bpE[nAcc], bpP[nAcc]);
        else ifc.in_valid = 1'b0;
      end
      if (cyc == 3) ifc.out_ready = 1'b1;
    end
    checkOutput("bp_accepted", 64'(nAcc), 64'd5);
    for (int k = 0; k < 30 && expQ.size() != 0; k++) @(posedge clk);
    #1 checkOutput("bp_drain", 64'(expQ.size()), 64'd0);

    // Reset with two results in flight.
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    makeRandomOp(s, e, p);
    applyStimulus(1'b1, s, e, p);
    @(posedge clk);
    #1 makeRandomOp(s, e, p);
    applyStimulus(1'b1, s, e, p);
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    checkOutput("inflight_valid", 64'(ifc.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("rst_async_result", 64'(ifc.out_result), 64'd0);
    checkOutput("rst_async_flags", 64'(ifc.out_flags), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("no_stale", 64'(ifc.out_valid), 64'd0);
    end

    // Accumulated flags: clear, one overflow result, then clear again.
    @(posedge clk);
    #1 flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    checkOutput("sticky_cleared", 64'(flags_sticky), 64'd0);
    applyStimulus(1'b0, 1'b0, 10'd254, 48'h8000_0000_0000);
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef FP_NORM_STICKY_FLAGS_EN
    checkOutput("sticky_overflow", 64'(flags_sticky), 64'b101);
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    checkOutput("sticky_after_clr", 64'(flags_sticky), 64'b000);
`else
    checkOutput("sticky_disabled", 64'(flags_sticky), 64'b000);
`endif

    // Randomized traffic with random backpressure; operands held until accepted.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      acc = ifc.in_valid && ifc.in_ready;
      @(posedge clk);
      #1;
      if (!ifc.in_valid || acc) begin
        makeRandomOp(s, e, p);
        applyStimulus($urandom_range(0, 9) < 7, s, e, p);
      end
      ifc.out_ready = $urandom_range(0, 9) < 7;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 30 && expQ.size() != 0; k++) @(posedge clk);
    #1 checkOutput("random_drain", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Normalize-and-round stage of the single-precision floating-point multiplier. It sits directly downstream of the final carry-propagate adder of the Wallace-tree mantissa multiplier and consumes its 48-bit raw product together with the pre-computed sign and exponent sum. It normalizes the product, rounds it to nearest-even, handles exponent overflow and underflow, and packs an IEEE-754 single result. It is a two-stage valid/ready pipeline.

## Interface
- `PW`, 48: product width (24×24 mantissa product).
- `EW`, 10: signed exponent-sum width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds valid operands.
- `in_ready`  out  1  stage accepts operands this cycle.
- `in_sign`  in  1  result sign (signA ^ signB).
- `in_exp`  in  EW  signed biased exponent sum, expA + expB − 127.
- `in_prod`  in  PW  raw mantissa product, hidden bits included.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_result`  out  32  packed IEEE-754 single.
- `out_flags`  out  3  {overflow, underflow, inexact} for `out_result`.
- `flag_clr`  in  1  clears the sticky flags (used only with the macro).
- `flags_sticky`  out  3  accumulated flags (used only with the macro).

## Operation
- Stage 1 (normalize):
  - Zero: `in_prod[47:46]==0`.
  - If `in_prod[47]`: mant=`in_prod[46:24]`, guard=`in_prod[23]`, sticky=`|in_prod[22:0]`, exp=`in_exp+1`.
  - Otherwise: mant=`in_prod[45:23]`, guard=`in_prod[22]`, sticky=`|in_prod[21:0]`, exp=`in_exp`.
- Stage 2 (round and pack):
  - Round-to-nearest-even: increment when guard & (sticky | mant[0]).
  - If the increment carries out of 23 bits: mant=0, exp+1.
  - inexact = guard | sticky.
- Exponent checks apply to the post-round exponent, evaluated in EW+1 signed bits:
  - exp ≥ 255 → {sign, 8'hFF, 23'h0}; overflow=1, inexact=1.
  - exp ≤ 0 → {sign, 31'h0}, flush-to-zero with no subnormals; underflow=1, inexact=1.
- Zero product → {sign, 31'h0}; flags=0. This takes priority over the exponent checks.
- NaN and infinity operands are handled upstream and are never presented here.

## Timing
- Latency: 2 cycles from the accepting edge to `out_valid` when there is no stall.
- Throughput: 1 result per cycle.
- Transfer rules:
  - Input transfer occurs when `in_valid & in_ready`.
  - Output transfer occurs when `out_valid & out_ready`.
- Stall rules:
  - Stage 2 advances when it is empty or `out_ready`=1.
  - Stage 1 advances when it is empty or stage 2 advances.
  - `in_ready` equals stage 1 advance. It is combinational from `out_ready` and must never depend on `in_valid`.
- Output stability: while `out_valid & !out_ready`, `out_result` and `out_flags` hold stable.
- Capacity: holds 2 results in flight. Results are never dropped or reordered.
- Reset: asynchronous and immediate. Everything in flight is discarded.
  - `out_valid`=0, `out_result`=0, `out_flags`=0, `flags_sticky`=0.
  - `in_ready` reads 1 after reset.

## Configuration
- `FP_NORM_STICKY_FLAGS_EN` defined:
  - `flags_sticky` ORs in `out_flags` on every output transfer.
  - `flag_clr` zeroes it on the next edge.
  - If a clear and a transfer happen in the same cycle, the result is the new transfer's flags only.
- Not defined:
  - `flags_sticky` is tied to 0.
  - `flag_clr` is ignored.
  - No sticky registers are synthesized.

## Test plan
- `in_prod`=48'h4000_0000_0000, `in_exp`=127, `in_sign`=0, `out_ready`=1 → `out_result`=32'h3F80_0000, flags=0, exactly 2 cycles later.
- `in_prod`=48'h9000_0000_0000, `in_exp`=127 → 32'h4010_0000 (2.25), flags=0.
- Rounding cases, `in_exp`=127:
  - `in_prod`=48'h4000_0040_0000 (tie, even LSB) → 32'h3F80_0000, inexact=1.
  - `in_prod`=48'h4000_00C0_0000 (tie, odd LSB) → 32'h3F80_0002, inexact=1.
- Exponent limits:
  - `in_exp`=254, `in_prod`=48'h8000_0000_0000 → 32'h7F80_0000, overflow=1, inexact=1.
  - `in_exp`=0, `in_prod`=48'h4000_0000_0000, sign=1 → 32'h8000_0000, underflow=1, inexact=1.
- Backpressure: stream 5 back-to-back operands while `out_ready`=0 for 4 cycles.
  - `in_ready` falls after 2 acceptances.
  - All 5 results emerge in order with no duplicates.
  - `out_result` stays stable while stalled.
- Reset and sticky flags:
  - Assert `rst` with 2 results in flight → `out_valid` drops at once, and no stale result appears after release.
  - With `FP_NORM_STICKY_FLAGS_EN`, an overflow result followed by `flag_clr` → `flags_sticky` goes 3'b101 then 3'b000.
